rc6_arb_ctrl: RTL

//  Shares one rc6_core (128-bit key, 20 rounds) between two block requesters (ch0, ch1).

---
 rtl/rc6_arb_ctrl.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/rc6_arb_ctrl.sv
// Two-channel round-robin front end for a single rc6_core: grants one block
// request at a time, caches the expanded key and sequences key/data/result.
module rc6_arb_ctrl #(
    parameter int KEY_SETTLE = 2,
    parameter int TIMEOUT    = 1023,
    parameter int DATA_W     = 128
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req0_valid,
    output logic              o_req0_ready,
    input  logic [DATA_W-1:0] i_req0_key,
    input  logic              i_req0_flag,
    input  logic [DATA_W-1:0] i_req0_din,
    input  logic              i_req1_valid,
    output logic              o_req1_ready,
    input  logic [DATA_W-1:0] i_req1_key,
    input  logic              i_req1_flag,
    input  logic [DATA_W-1:0] i_req1_din,
    output logic              o_rsp0_valid,
    input  logic              i_rsp0_ready,
    output logic              o_rsp1_valid,
    input  logic              i_rsp1_ready,
    output logic [DATA_W-1:0] o_rsp_dout,
    output logic              o_core_key_en,
    output logic [DATA_W-1:0] o_core_key,
    input  logic              i_core_key_ok,
    output logic              o_core_din_en,
    output logic              o_core_flag,
    output logic [DATA_W-1:0] o_core_din,
    input  logic              i_core_dout_en,
    input  logic [DATA_W-1:0] i_core_dout,
    output logic              o_busy,
    output logic              o_timeout
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_GRANT     = 3'd1,
        ST_KEY_LOAD  = 3'd2,
        ST_KEY_WAIT  = 3'd3,
        ST_DATA      = 3'd4,
        ST_DATA_WAIT = 3'd5,
        ST_RESP      = 3'd6
    } state_t;

    localparam logic [9:0] SETTLE_CNT = 10'(KEY_SETTLE);
    localparam logic [9:0] TMO_LAST   = 10'(TIMEOUT - 1);

    state_t            state_q;
    state_t            state_d;
    logic              gnt_q;
    logic              last_q;
    logic              key_vld_q;
    logic [9:0]        cnt_q;
    logic              timeout_q;
    logic [DATA_W-1:0] core_key_q;
    logic [DATA_W-1:0] core_din_q;
    logic              core_flag_q;
    logic [DATA_W-1:0] rsp_dout_q;
    logic [DATA_W-1:0] lat_key;
    logic [DATA_W-1:0] lat_din;
    logic              lat_flag;

    logic              any_valid;
    logic              pick_ch;
    logic              accept;
    logic              key_hit;
    logic              tmo_hit;
    logic              rsp_take;
    logic              wait_state;
    logic              tmo_exit;

    // Arbitration: with both channels pending, the one not served last wins.
    always_comb begin
        any_valid  = i_req0_valid || i_req1_valid;
        pick_ch    = (i_req0_valid && i_req1_valid) ? ~last_q : i_req1_valid;
        accept     = (state_q == ST_IDLE) && any_valid;
        key_hit    = key_vld_q && (lat_key == core_key_q);
        tmo_hit    = (cnt_q == TMO_LAST);
        rsp_take   = gnt_q ? i_rsp1_ready : i_rsp0_ready;
        wait_state = (state_q == ST_KEY_WAIT) || (state_q == ST_DATA_WAIT);
        tmo_exit   = wait_state && (state_d == ST_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (any_valid) state_d = ST_GRANT;
            end
            ST_GRANT: begin
                state_d = key_hit ? ST_DATA : ST_KEY_LOAD;
            end
            ST_KEY_LOAD: begin
                state_d = ST_KEY_WAIT;
            end
            ST_KEY_WAIT: begin
                // key_ok may still be high from the previous key during the settle window.
                if ((cnt_q >= SETTLE_CNT) && i_core_key_ok) state_d = ST_DATA;
                else if (tmo_hit)                           state_d = ST_IDLE;
            end
            ST_DATA: begin
                state_d = ST_DATA_WAIT;
            end
            ST_DATA_WAIT: begin
                if (i_core_dout_en) state_d = ST_RESP;
                else if (tmo_hit)   state_d = ST_IDLE;
            end
            ST_RESP: begin
                if (rsp_take) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        o_req0_ready  = i_rst_n && accept && !pick_ch;
        o_req1_ready  = i_rst_n && accept && pick_ch;
        o_core_key_en = (state_q == ST_KEY_LOAD);
        o_core_din_en = (state_q == ST_DATA);
        o_rsp0_valid  = (state_q == ST_RESP) && !gnt_q;
        o_rsp1_valid  = (state_q == ST_RESP) && gnt_q;
        o_busy        = (state_q != ST_IDLE);
        o_timeout     = timeout_q;
        o_core_key    = core_key_q;
        o_core_din    = core_din_q;
        o_core_flag   = core_flag_q;
        o_rsp_dout    = rsp_dout_q;
    end

    // Request payload is sampled once at acceptance; later changes are ignored.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            lat_key  <= pick_ch ? i_req1_key  : i_req0_key;
            lat_din  <= pick_ch ? i_req1_din  : i_req0_din;
            lat_flag <= pick_ch ? i_req1_flag : i_req0_flag;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            gnt_q       <= 1'b0;
            last_q      <= 1'b1;
            key_vld_q   <= 1'b0;
            cnt_q       <= 10'd0;
            timeout_q   <= 1'b0;
            core_key_q  <= '0;
            core_din_q  <= '0;
            core_flag_q <= 1'b0;
            rsp_dout_q  <= '0;
        end else begin
            if (accept) begin
                gnt_q <= pick_ch;
            end
            if (state_d != state_q) begin
                cnt_q <= 10'd0;
            end else if (wait_state) begin
                cnt_q <= cnt_q + 10'd1;
            end
            // The core key register doubles as the key cache.
            if ((state_q == ST_GRANT) && (state_d == ST_KEY_LOAD)) begin
                core_key_q <= lat_key;
                key_vld_q  <= 1'b0;
            end else if ((state_q == ST_KEY_WAIT) && (state_d == ST_DATA)) begin
                key_vld_q  <= 1'b1;
            end else if (tmo_exit) begin
                key_vld_q  <= 1'b0;
            end
            if (tmo_exit) begin
                timeout_q <= 1'b1;
            end
            if ((state_d == ST_DATA) && (state_q != ST_DATA)) begin
                core_din_q  <= lat_din;
                core_flag_q <= lat_flag;
            end
            if ((state_q == ST_DATA_WAIT) && i_core_dout_en) begin
                rsp_dout_q <= i_core_dout;
            end
            if ((state_q == ST_RESP) && rsp_take) begin
                last_q <= gnt_q;
            end
        end
    end

endmodule
